writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Four-source writeback arbiter: per-source FIFOs, rotating-priority grant,
// registered writeback port and a saturating count of phy-0 drops.
module writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_valid,
  input  logic        load_valid,
  input  logic        mul_valid,
  input  logic        div_valid,
  output logic        add_ready,
  output logic        load_ready,
  output logic        mul_ready,
  output logic        div_ready,
  input  logic [31:0] add_data,
  input  logic [31:0] load_data,
  input  logic [31:0] mul_data,
  input  logic [31:0] div_data,
  input  logic [7:0]  add_phy,
  input  logic [7:0]  load_phy,
  input  logic [7:0]  mul_phy,
  input  logic [7:0]  div_phy,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [7:0]  wb_phy,
  output logic [1:0]  wb_src,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [3:0]    in_valid;
  logic [31:0]   in_data [4];
  logic [7:0]    in_phy  [4];

  logic [31:0]   mem_data_q [4][DEPTH];
  logic [7:0]    mem_phy_q  [4][DEPTH];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [CW-1:0] cnt_q    [4];

  logic [1:0]    rr_ptr_q;
  logic          wb_valid_q;
  logic [31:0]   wb_data_q;
  logic [7:0]    wb_phy_q;
  logic [1:0]    wb_src_q;
  logic [15:0]   drop_cnt_q;
  logic [15:0]   drop_cnt_d;

  logic [3:0]    ready;
  logic [3:0]    push;
  logic [3:0]    drop;
  logic [3:0]    nonempty;
  logic [3:0]    pop;
  logic [2:0]    drop_sum;
  logic          grant;
  logic [1:0]    win;
  logic [1:0]    cand;

  assign in_valid   = {div_valid, mul_valid, load_valid, add_valid};
  assign in_data[0] = add_data;
  assign in_data[1] = load_data;
  assign in_data[2] = mul_data;
  assign in_data[3] = div_data;
  assign in_phy[0]  = add_phy;
  assign in_phy[1]  = load_phy;
  assign in_phy[2]  = mul_phy;
  assign in_phy[3]  = div_phy;

  // Ready comes from the registered count alone and is forced low while in reset.
  always_comb begin
    ready    = 4'b0;
    push     = 4'b0;
    drop     = 4'b0;
    nonempty = 4'b0;
    drop_sum = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ready[i]    = reset && (cnt_q[i] < CW'(DEPTH));
      push[i]     = in_valid[i] && ready[i] && (in_phy[i] != 8'h00);
      drop[i]     = in_valid[i] && ready[i] && (in_phy[i] == 8'h00);
      nonempty[i] = (cnt_q[i] != '0);
      drop_sum    = drop_sum + {2'b00, drop[i]};
    end
  end

  assign add_ready  = ready[0];
  assign load_ready = ready[1];
  assign mul_ready  = ready[2];
  assign div_ready  = ready[3];

  // Rotating priority: first non-empty source at or after rr_ptr wins.
  always_comb begin
    grant = 1'b0;
    win   = rr_ptr_q;
    cand  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!grant && nonempty[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  assign pop        = grant ? (4'b0001 << win) : 4'b0000;
  assign drop_cnt_d = sat_add16(drop_cnt_q, drop_sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q   <= 2'd0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'h0;
      wb_phy_q   <= 8'h0;
      wb_src_q   <= 2'd0;
      drop_cnt_q <= 16'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
      wb_valid_q <= grant;
      if (grant) begin
        wb_data_q <= mem_data_q[win][rd_ptr_q[win]];
        wb_phy_q  <= mem_phy_q[win][rd_ptr_q[win]];
        wb_src_q  <= win;
        rr_ptr_q  <= win + 2'd1;
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is qualified by the counts, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_data_q[i][wr_ptr_q[i]] <= in_data[i];
        mem_phy_q[i][wr_ptr_q[i]]  <= in_phy[i];
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_phy     = wb_phy_q;
  assign wb_src     = wb_src_q;
  assign drop_count = drop_cnt_q;

endmodule
